// File: rtl/multisim_pull_pkg.sv
// Shared types and default backoff delays for the multisim pull scheduler.
// Imported by the scheduler top and its round-robin arbiter.
package multisim_pull_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  localparam int DELAY_ACTIVE_DEF   = 0;
  localparam int DELAY_INACTIVE_DEF = 3;

endpackage

// File: rtl/multisim_rr_arb.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps.
// Returns a one-hot grant plus the binary index of the winner.
module multisim_rr_arb
  import multisim_pull_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IW = $clog2(N);

  always_comb begin : p_arb
    logic found;
    int   c;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int k = 0; k < N; k++) begin
      c = (int'(ptr) + k) % N;
      if (!found && req[c]) begin
        found  = 1'b1;
        gnt[c] = 1'b1;
        idx    = IW'(c);
      end
    end
  end

endmodule

// File: rtl/multisim_pull_sched.sv
// Shares one DPI pull channel among N_CH consumers, round-robin, one pull
// outstanding, with a 1-entry result buffer and hit/miss backoff per consumer.
module multisim_pull_sched
  import multisim_pull_pkg::*;
#(
  parameter int N_CH           = 4,
  parameter int DATA_W         = 8,
  parameter int DELAY_ACTIVE   = DELAY_ACTIVE_DEF,
  parameter int DELAY_INACTIVE = DELAY_INACTIVE_DEF,
  parameter int DLY_W          = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  output logic                     pull_req,
  output logic [$clog2(N_CH)-1:0]  pull_req_ch,
  input  logic                     pull_ack,
  input  logic                     pull_rsp_vld,
  input  logic                     pull_rsp_hit,
  input  logic [DATA_W-1:0]        pull_rsp_data,
  output logic [N_CH-1:0]          ch_vld,
  input  logic [N_CH-1:0]          ch_rdy,
  output logic [N_CH*DATA_W-1:0]   ch_data,
  output logic                     busy
);

  localparam int IW = $clog2(N_CH);
  localparam logic [DLY_W-1:0] DA = DLY_W'(DELAY_ACTIVE);
  localparam logic [DLY_W-1:0] DI = DLY_W'(DELAY_INACTIVE);

  state_e state, state_n;

  logic [N_CH-1:0][DLY_W-1:0] bo_cnt;
  logic [N_CH-1:0] elig;
  logic [N_CH-1:0] win_gnt;
  logic [N_CH-1:0] rsp_sel;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   ptr;
  logic            grant;
  logic            rsp_take;

  always_comb begin
    elig = '0;
    for (int i = 0; i < N_CH; i++) begin
      elig[i] = !ch_vld[i] && (bo_cnt[i] == '0);
    end
  end

  multisim_rr_arb #(
    .N (N_CH)
  ) u_arb (
    .req (elig),
    .ptr (ptr),
    .gnt (win_gnt),
    .idx (win_idx)
  );

  // Same-cycle ack+response in REQ behaves as ack followed by response.
  always_comb begin
    state_n  = state;
    grant    = 1'b0;
    rsp_take = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable && |win_gnt) begin
          grant   = 1'b1;
          state_n = REQ;
        end
      end
      REQ: begin
        if (pull_ack) begin
          if (pull_rsp_vld) begin
            rsp_take = 1'b1;
            state_n  = IDLE;
          end else begin
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        if (pull_rsp_vld) begin
          rsp_take = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign rsp_sel = rsp_take ? (N_CH'(1) << pull_req_ch) : '0;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pull_req    <= 1'b0;
      pull_req_ch <= '0;
      ptr         <= '0;
    end else begin
      state    <= state_n;
      pull_req <= (state_n == REQ);
      if (grant) begin
        pull_req_ch <= win_idx;
        ptr <= (win_idx == IW'(N_CH - 1)) ? '0 : win_idx + IW'(1);
      end
    end
  end

  // A response load takes priority over the backoff decrement.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ch_vld  <= '0;
      ch_data <= '0;
      bo_cnt  <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (rsp_sel[i]) begin
          bo_cnt[i] <= pull_rsp_hit ? DA : DI;
          if (pull_rsp_hit) begin
            ch_vld[i] <= 1'b1;
            ch_data[i*DATA_W +: DATA_W] <= pull_rsp_data;
          end
        end else begin
          if (bo_cnt[i] != '0) begin
            bo_cnt[i] <= bo_cnt[i] - DLY_W'(1);
          end
          if (ch_vld[i] && ch_rdy[i]) begin
            ch_vld[i] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_multisim_pull_sched.sv
// Directed bench for multisim_pull_sched: reset, round-robin, miss backoff,
// consumer stall, delayed/same-cycle ack, enable drop and mid-flight reset.
module tb_multisim_pull_sched;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        pull_req;
  logic [1:0]  pull_req_ch;
  logic        pull_ack;
  logic        pull_rsp_vld;
  logic        pull_rsp_hit;
  logic [7:0]  pull_rsp_data;
  logic [3:0]  ch_vld;
  logic [3:0]  ch_rdy;
  logic [31:0] ch_data;
  logic        busy;

  int tests;
  int fails;

  multisim_pull_sched dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .pull_req      (pull_req),
    .pull_req_ch   (pull_req_ch),
    .pull_ack      (pull_ack),
    .pull_rsp_vld  (pull_rsp_vld),
    .pull_rsp_hit  (pull_rsp_hit),
    .pull_rsp_data (pull_rsp_data),
    .ch_vld        (ch_vld),
    .ch_rdy        (ch_rdy),
    .ch_data       (ch_data),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n         = 1'b0;
    enable        = 1'b0;
    pull_ack      = 1'b0;
    pull_rsp_vld  = 1'b0;
    pull_rsp_hit  = 1'b0;
    pull_rsp_data = 8'h00;
    ch_rdy        = 4'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Server model: wait for a request, ack after ack_dly cycles, respond.
  task automatic serve(input int ack_dly, input bit hit, input int k,
                       input bit same, output int ch, output bit ok);
    int t;
    t = 0;
    while (pull_req !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    ok = (pull_req === 1'b1);
    ch = int'(pull_req_ch);
    if (!ok) return;
    repeat (ack_dly) @(negedge clk);
    pull_ack      = 1'b1;
    pull_rsp_hit  = hit;
    pull_rsp_data = 8'(ch * 16 + k);
    if (same) pull_rsp_vld = 1'b1;
    @(negedge clk);
    pull_ack = 1'b0;
    if (!same) begin
      pull_rsp_vld = 1'b1;
      @(negedge clk);
    end
    pull_rsp_vld = 1'b0;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    enable        = 1'b1;
    pull_ack      = 1'b1;
    pull_rsp_vld  = 1'b1;
    pull_rsp_hit  = 1'b1;
    pull_rsp_data = 8'hFF;
    ch_rdy        = 4'hF;
    repeat (3) @(negedge clk);
    tests++;
    if (pull_req !== 1'b0 || pull_req_ch !== 2'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctl got req=%b ch=%0d busy=%b exp 0/0/0",
               pull_req, pull_req_ch, busy);
    end
    tests++;
    if (ch_vld !== 4'h0 || ch_data !== 32'h0) begin
      fails++;
      $display("FAIL reset_data got vld=%h data=%h exp 0/0", ch_vld, ch_data);
    end
    pull_ack     = 1'b0;
    pull_rsp_vld = 1'b0;
    enable       = 1'b0;
    rst_n        = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || pull_req !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle got busy=%b req=%b exp 0/0", busy, pull_req);
    end
  endtask

  task automatic test_round_robin();
    int exp_seq[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int ch;
    bit ok;
    do_reset();
    ch_rdy = 4'hF;
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      serve(0, 1'b1, i, 1'b0, ch, ok);
      tests++;
      if (!ok || ch != exp_seq[i]) begin
        fails++;
        $display("FAIL rr_grant[%0d] got %0d exp %0d", i, ch, exp_seq[i]);
      end
      tests++;
      if (ch_vld[exp_seq[i]] !== 1'b1 ||
          ch_data[exp_seq[i]*8 +: 8] !== 8'(exp_seq[i] * 16 + i)) begin
        fails++;
        $display("FAIL rr_data[%0d] got vld=%b data=%h exp 1/%h", i,
                 ch_vld[exp_seq[i]], ch_data[exp_seq[i]*8 +: 8],
                 8'(exp_seq[i] * 16 + i));
      end
    end
  endtask

  task automatic test_miss_backoff();
    int ch;
    bit ok;
    bit quiet;
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 4; i++) serve(0, 1'b1, i, 1'b0, ch, ok);
    tests++;
    if (ch_vld !== 4'hF) begin
      fails++;
      $display("FAIL miss_fill got vld=%h exp f", ch_vld);
    end
    ch_rdy = 4'b0100;
    serve(0, 1'b0, 7, 1'b0, ch, ok);
    tests++;
    if (!ok || ch != 2 || ch_vld !== 4'b1011) begin
      fails++;
      $display("FAIL miss_rsp got ch=%0d vld=%h exp 2/b", ch, ch_vld);
    end
    quiet = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (pull_req !== 1'b0) quiet = 1'b0;
      @(negedge clk);
    end
    tests++;
    if (!quiet) begin
      fails++;
      $display("FAIL miss_backoff got early req exp 4 idle cycles");
    end
    tests++;
    if (pull_req !== 1'b1 || pull_req_ch !== 2'd2) begin
      fails++;
      $display("FAIL miss_regrant got req=%b ch=%0d exp 1/2",
               pull_req, pull_req_ch);
    end
    serve(0, 1'b1, 9, 1'b0, ch, ok);
    tests++;
    if (ch_vld[2] !== 1'b1 || ch_data !== 32'h33_29_11_00) begin
      fails++;
      $display("FAIL miss_others got vld=%h data=%h exp 33291100",
               ch_vld, ch_data);
    end
  endtask

  task automatic test_stall();
    int exp_a[6] = '{0, 1, 2, 3, 0, 2};
    int exp_b[3] = '{3, 0, 1};
    int ch;
    bit ok;
    do_reset();
    ch_rdy = 4'b1101;
    enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      serve(0, 1'b1, i, 1'b0, ch, ok);
      tests++;
      if (!ok || ch != exp_a[i]) begin
        fails++;
        $display("FAIL stall_grant[%0d] got %0d exp %0d", i, ch, exp_a[i]);
      end
    end
    ch_rdy = 4'hF;
    for (int i = 0; i < 3; i++) begin
      serve(0, 1'b1, 10 + i, 1'b0, ch, ok);
      tests++;
      if (!ok || ch != exp_b[i]) begin
        fails++;
        $display("FAIL resume_grant[%0d] got %0d exp %0d", i, ch, exp_b[i]);
      end
    end
    tests++;
    if (ch_data[15:8] !== 8'h1C) begin
      fails++;
      $display("FAIL resume_data got %h exp 1c", ch_data[15:8]);
    end
  endtask

  task automatic test_ack_delay();
    int  t;
    bit  stable;
    do_reset();
    ch_rdy = 4'h0;
    enable = 1'b1;
    t = 0;
    while (pull_req !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    enable = 1'b0;
    stable = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (pull_req !== 1'b1 || pull_req_ch !== 2'd0 || busy !== 1'b1)
        stable = 1'b0;
      @(negedge clk);
    end
    tests++;
    if (!stable) begin
      fails++;
      $display("FAIL ack_hold got unstable req exp req=1 ch=0 for 5 cycles");
    end
    pull_ack      = 1'b1;
    pull_rsp_vld  = 1'b1;
    pull_rsp_hit  = 1'b1;
    pull_rsp_data = 8'hA5;
    @(negedge clk);
    pull_ack     = 1'b0;
    pull_rsp_vld = 1'b0;
    tests++;
    if (ch_vld !== 4'b0001 || ch_data[7:0] !== 8'hA5) begin
      fails++;
      $display("FAIL same_cycle_data got vld=%h d=%h exp 1/a5",
               ch_vld, ch_data[7:0]);
    end
    tests++;
    if (busy !== 1'b0 || pull_req !== 1'b0) begin
      fails++;
      $display("FAIL same_cycle_idle got busy=%b req=%b exp 0/0",
               busy, pull_req);
    end
  endtask

  task automatic test_enable_reset();
    int  t;
    bit  quiet;
    do_reset();
    ch_rdy = 4'h0;
    enable = 1'b1;
    t = 0;
    while (pull_req !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    pull_ack = 1'b1;
    @(negedge clk);
    pull_ack      = 1'b0;
    enable        = 1'b0;
    pull_rsp_vld  = 1'b1;
    pull_rsp_hit  = 1'b1;
    pull_rsp_data = 8'h05;
    @(negedge clk);
    pull_rsp_vld = 1'b0;
    tests++;
    if (ch_vld !== 4'b0001 || ch_data[7:0] !== 8'h05 || busy !== 1'b0) begin
      fails++;
      $display("FAIL en_drop_rsp got vld=%h d=%h busy=%b exp 1/05/0",
               ch_vld, ch_data[7:0], busy);
    end
    quiet = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (pull_req !== 1'b0) quiet = 1'b0;
      @(negedge clk);
    end
    tests++;
    if (!quiet) begin
      fails++;
      $display("FAIL en_drop_quiet got pull_req while disabled exp none");
    end
    enable = 1'b1;
    t = 0;
    while (pull_req !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    tests++;
    if (pull_req !== 1'b1 || pull_req_ch !== 2'd1) begin
      fails++;
      $display("FAIL rst_pre_grant got req=%b ch=%0d exp 1/1",
               pull_req, pull_req_ch);
    end
    enable   = 1'b0;
    pull_ack = 1'b1;
    @(negedge clk);
    pull_ack = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n         = 1'b1;
    pull_rsp_vld  = 1'b1;
    pull_rsp_hit  = 1'b1;
    pull_rsp_data = 8'hFF;
    @(negedge clk);
    pull_rsp_vld = 1'b0;
    tests++;
    if (ch_vld !== 4'h0 || ch_data !== 32'h0) begin
      fails++;
      $display("FAIL rst_stray_rsp got vld=%h data=%h exp 0/0",
               ch_vld, ch_data);
    end
    tests++;
    if (busy !== 1'b0 || pull_req !== 1'b0 || pull_req_ch !== 2'd0) begin
      fails++;
      $display("FAIL rst_mid_idle got busy=%b req=%b ch=%0d exp 0/0/0",
               busy, pull_req, pull_req_ch);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_round_robin();
    test_miss_backoff();
    test_stall();
    test_ack_delay();
    test_enable_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
